// File: rtl/dtl_gm_slave.sv
`default_nettype none
// ============================================================================
// Module   : dtl_gm_slave
// Purpose  : DTL block-command target driving a single-port synchronous SRAM.
//            Define DTL_GM_PROTOCOL_CHECK_EN to add the WriteLast check / oError.
// Revision : 1.0
// ============================================================================
module dtl_gm_slave #(
  parameter int INTERFACE_WIDTH       = 32,
  parameter int INTERFACE_ADDR_WIDTH  = 32,
  parameter int INTERFACE_BLOCK_WIDTH = 5,
  parameter int GM_MEM_ADDR_WIDTH     = 10
) (
  input  logic                             iClk,
  input  logic                             iReset,
  input  logic                             iDTL_CommandValid,
  output logic                             oDTL_CommandAccept,
  input  logic                             iDTL_CommandReadWrite,
  input  logic [INTERFACE_ADDR_WIDTH-1:0]  iDTL_Address,
  input  logic [INTERFACE_BLOCK_WIDTH-1:0] iDTL_BlockSize,
  input  logic                             iDTL_WriteValid,
  output logic                             oDTL_WriteAccept,
  input  logic [INTERFACE_WIDTH/8-1:0]     iDTL_WriteEnable,
  input  logic [INTERFACE_WIDTH-1:0]       iDTL_WriteData,
  input  logic                             iDTL_WriteLast,
  output logic                             oDTL_ReadValid,
  input  logic                             iDTL_ReadAccept,
  output logic [INTERFACE_WIDTH-1:0]       oDTL_ReadData,
  output logic                             oDTL_ReadLast,
  output logic [GM_MEM_ADDR_WIDTH-1:0]     oMEM_Address,
  output logic [INTERFACE_WIDTH/8-1:0]     oMEM_WriteEnable,
  output logic [INTERFACE_WIDTH-1:0]       oMEM_WriteData,
  output logic                             oMEM_ReadEnable,
  input  logic [INTERFACE_WIDTH-1:0]       iMEM_ReadData
`ifdef DTL_GM_PROTOCOL_CHECK_EN
  ,
  output logic                             oError
`endif
);

  localparam int c_CNT_WIDTH = INTERFACE_BLOCK_WIDTH + 1;
  localparam logic [c_CNT_WIDTH-1:0]       c_CNT_ONE  = 1;
  localparam logic [GM_MEM_ADDR_WIDTH-1:0] c_ADDR_ONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t                         r_state;
  logic [GM_MEM_ADDR_WIDTH-1:0]   r_addr;
  logic [c_CNT_WIDTH-1:0]         r_issueCnt;  // write beats left, or SRAM reads left to issue
  logic [c_CNT_WIDTH-1:0]         r_popCnt;
  logic                           r_cmdAccept;
  logic                           r_writeAccept;
  logic                           r_dataValid; // iMEM_ReadData carries a beat this cycle
  logic [INTERFACE_WIDTH-1:0]     r_fifo [2];
  logic                           r_wrPtr;
  logic                           r_rdPtr;
  logic [1:0]                     r_count;

  logic                           w_fifoNonEmpty;
  logic                           w_readValid;
  logic                           w_pop;
  logic                           w_push;
  logic                           w_fifoPop;
  logic [2:0]                     w_occAfter;
  logic                           w_issue;
  logic                           w_cmdTake;
  logic                           w_wrBeat;
  logic                           w_wrFinal;
  logic [GM_MEM_ADDR_WIDTH-1:0]   w_cmdWord;
  logic                           w_unused;

  // SRAM data bypasses the FIFO when it is empty so the first beat shows one cycle after the strobe.
  assign w_fifoNonEmpty = (r_count != 2'd0);
  assign w_readValid    = w_fifoNonEmpty | r_dataValid;
  assign w_pop          = w_readValid & iDTL_ReadAccept;
  assign w_push         = r_dataValid & (w_fifoNonEmpty | ~iDTL_ReadAccept);
  assign w_fifoPop      = w_pop & w_fifoNonEmpty;
  assign w_occAfter     = {1'b0, r_count} + {2'b00, r_dataValid} + {2'b00, oMEM_ReadEnable}
                          - {2'b00, w_pop};
  assign w_issue        = (r_state == ST_READ) & (r_issueCnt != '0) & (w_occAfter < 3'd2);
  assign w_cmdTake      = r_cmdAccept & iDTL_CommandValid;
  assign w_wrBeat       = r_writeAccept & iDTL_WriteValid;
  assign w_cmdWord      = iDTL_Address[GM_MEM_ADDR_WIDTH+1:2];

`ifdef DTL_GM_PROTOCOL_CHECK_EN
  assign w_wrFinal = (r_issueCnt == c_CNT_ONE) | iDTL_WriteLast;
  assign w_unused  = &{1'b0, iDTL_Address};
`else
  assign w_wrFinal = (r_issueCnt == c_CNT_ONE);
  assign w_unused  = &{1'b0, iDTL_Address, iDTL_WriteLast};
`endif

  assign oDTL_CommandAccept = r_cmdAccept & iReset;
  assign oDTL_WriteAccept   = r_writeAccept;
  assign oDTL_ReadValid     = w_readValid;
  assign oDTL_ReadLast      = w_readValid & (r_popCnt == c_CNT_ONE);
  assign oDTL_ReadData      = w_fifoNonEmpty ? r_fifo[r_rdPtr] :
                              (r_dataValid ? iMEM_ReadData : '0);

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      r_state          <= ST_IDLE;
      r_addr           <= '0;
      r_issueCnt       <= '0;
      r_popCnt         <= '0;
      r_cmdAccept      <= 1'b1;
      r_writeAccept    <= 1'b0;
      r_dataValid      <= 1'b0;
      r_fifo[0]        <= '0;
      r_fifo[1]        <= '0;
      r_wrPtr          <= 1'b0;
      r_rdPtr          <= 1'b0;
      r_count          <= 2'd0;
      oMEM_Address     <= '0;
      oMEM_WriteEnable <= '0;
      oMEM_WriteData   <= '0;
      oMEM_ReadEnable  <= 1'b0;
`ifdef DTL_GM_PROTOCOL_CHECK_EN
      oError           <= 1'b0;
`endif
    end else begin
      oMEM_WriteEnable <= '0;
      oMEM_ReadEnable  <= 1'b0;
      r_dataValid      <= oMEM_ReadEnable;

      if (w_push) begin
        r_fifo[r_wrPtr] <= iMEM_ReadData;
        r_wrPtr         <= ~r_wrPtr;
      end
      if (w_fifoPop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_fifoPop};

      case (r_state)
        ST_IDLE: begin
          if (w_cmdTake) begin
            r_cmdAccept <= 1'b0;
            if (iDTL_CommandReadWrite) begin
              r_state       <= ST_WRITE;
              r_writeAccept <= 1'b1;
              r_addr        <= w_cmdWord;
              r_issueCnt    <= {1'b0, iDTL_BlockSize} + c_CNT_ONE;
            end else begin
              // First read goes out straight away; BlockSize is the count still to issue.
              r_state         <= ST_READ;
              oMEM_ReadEnable <= 1'b1;
              oMEM_Address    <= w_cmdWord;
              r_addr          <= w_cmdWord + c_ADDR_ONE;
              r_issueCnt      <= {1'b0, iDTL_BlockSize};
              r_popCnt        <= {1'b0, iDTL_BlockSize} + c_CNT_ONE;
            end
          end
        end
        ST_WRITE: begin
          if (w_wrBeat) begin
            oMEM_WriteEnable <= iDTL_WriteEnable;
            oMEM_WriteData   <= iDTL_WriteData;
            oMEM_Address     <= r_addr;
            r_addr           <= r_addr + c_ADDR_ONE;
            r_issueCnt       <= r_issueCnt - c_CNT_ONE;
`ifdef DTL_GM_PROTOCOL_CHECK_EN
            if (iDTL_WriteLast != (r_issueCnt == c_CNT_ONE)) begin
              oError <= 1'b1;
            end
`endif
            if (w_wrFinal) begin
              r_state       <= ST_IDLE;
              r_writeAccept <= 1'b0;
              r_cmdAccept   <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (w_issue) begin
            oMEM_ReadEnable <= 1'b1;
            oMEM_Address    <= r_addr;
            r_addr          <= r_addr + c_ADDR_ONE;
            r_issueCnt      <= r_issueCnt - c_CNT_ONE;
          end
          if (w_pop) begin
            r_popCnt <= r_popCnt - c_CNT_ONE;
            if (r_popCnt == c_CNT_ONE) begin
              r_state     <= ST_IDLE;
              r_cmdAccept <= 1'b1;
            end
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_writeAccept <= 1'b0;
          r_cmdAccept   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dtl_gm_slave.sv
`default_nettype none
// Bench for dtl_gm_slave: directed vector table, reset/protocol sequences and
// random bursts checked against a word-array memory model.
module tb_dtl_gm_slave;

  localparam int W     = 32;
  localparam int AW    = 32;
  localparam int BW    = 5;
  localparam int GW    = 10;
  localparam int DEPTH = 1 << GW;

  logic          iClk;
  logic          iReset;
  logic          iDTL_CommandValid;
  logic          oDTL_CommandAccept;
  logic          iDTL_CommandReadWrite;
  logic [AW-1:0] iDTL_Address;
  logic [BW-1:0] iDTL_BlockSize;
  logic          iDTL_WriteValid;
  logic          oDTL_WriteAccept;
  logic [W/8-1:0] iDTL_WriteEnable;
  logic [W-1:0]  iDTL_WriteData;
  logic          iDTL_WriteLast;
  logic          oDTL_ReadValid;
  logic          iDTL_ReadAccept;
  logic [W-1:0]  oDTL_ReadData;
  logic          oDTL_ReadLast;
  logic [GW-1:0] oMEM_Address;
  logic [W/8-1:0] oMEM_WriteEnable;
  logic [W-1:0]  oMEM_WriteData;
  logic          oMEM_ReadEnable;
  logic [W-1:0]  iMEM_ReadData;
`ifdef DTL_GM_PROTOCOL_CHECK_EN
  logic          oError;
`endif

  dtl_gm_slave #(
    .INTERFACE_WIDTH(W), .INTERFACE_ADDR_WIDTH(AW),
    .INTERFACE_BLOCK_WIDTH(BW), .GM_MEM_ADDR_WIDTH(GW)
  ) dut (
    .iClk(iClk), .iReset(iReset),
    .iDTL_CommandValid(iDTL_CommandValid), .oDTL_CommandAccept(oDTL_CommandAccept),
    .iDTL_CommandReadWrite(iDTL_CommandReadWrite), .iDTL_Address(iDTL_Address),
    .iDTL_BlockSize(iDTL_BlockSize), .iDTL_WriteValid(iDTL_WriteValid),
    .oDTL_WriteAccept(oDTL_WriteAccept), .iDTL_WriteEnable(iDTL_WriteEnable),
    .iDTL_WriteData(iDTL_WriteData), .iDTL_WriteLast(iDTL_WriteLast),
    .oDTL_ReadValid(oDTL_ReadValid), .iDTL_ReadAccept(iDTL_ReadAccept),
    .oDTL_ReadData(oDTL_ReadData), .oDTL_ReadLast(oDTL_ReadLast),
    .oMEM_Address(oMEM_Address), .oMEM_WriteEnable(oMEM_WriteEnable),
    .oMEM_WriteData(oMEM_WriteData), .oMEM_ReadEnable(oMEM_ReadEnable),
    .iMEM_ReadData(iMEM_ReadData)
`ifdef DTL_GM_PROTOCOL_CHECK_EN
    , .oError(oError)
`endif
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int nCmp = 0;
  int nMis = 0;
  int expWrites = 0;
  int expReads = 0;
  int monIssued = 0;
  int monPopped = 0;
  int monWrites = 0;

  logic [W-1:0] sram   [DEPTH];
  logic [W-1:0] refMem [DEPTH];
  bit memReady = 1'b0;

  function automatic logic [W-1:0] initVal(input int i);
    return (i * 32'h9E37_79B9) ^ 32'hA5A5_0000;
  endfunction

  // SRAM stand-in: one-cycle read latency, byte-masked writes.
  always @(posedge iClk) begin
    if (!memReady) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= initVal(i);
      memReady <= 1'b1;
    end else begin
      if (oMEM_ReadEnable) iMEM_ReadData <= sram[oMEM_Address];
      for (int b = 0; b < W/8; b++)
        if (oMEM_WriteEnable[b]) sram[oMEM_Address][8*b +: 8] <= oMEM_WriteData[8*b +: 8];
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Mutual exclusion, outstanding-read cap and strobe counting.
  always @(negedge iClk) begin
    #2;
    if (!iReset) begin
      monPopped = monIssued;
    end else begin
      if (oMEM_ReadEnable) monIssued++;
      if (|oMEM_WriteEnable) monWrites++;
      nCmp++;
      if (oMEM_ReadEnable && |oMEM_WriteEnable) begin
        nMis++;
        $display("FAIL sram_rw_same_cycle: re=%0b we=%0h", oMEM_ReadEnable, oMEM_WriteEnable);
      end
      nCmp++;
      if (monIssued - monPopped > 2) begin
        nMis++;
        $display("FAIL outstanding_reads: got %0d, expected <= 2", monIssued - monPopped);
      end
      if (oDTL_ReadValid && iDTL_ReadAccept) monPopped++;
    end
  end

  task automatic nextCycle();
    @(posedge iClk);
    @(negedge iClk);
  endtask

  task automatic issueCmd(input bit rw, input logic [31:0] addr, input int bs);
    int t = 0;
    while (oDTL_CommandAccept !== 1'b1 && t < 50) begin nextCycle(); t++; end
    check("cmd_accept_ready", oDTL_CommandAccept, 1);
    iDTL_CommandValid = 1'b1; iDTL_CommandReadWrite = rw;
    iDTL_Address = addr; iDTL_BlockSize = BW'(bs);
    nextCycle();
    iDTL_CommandValid = 1'b0; iDTL_Address = $urandom; iDTL_BlockSize = BW'($urandom);
    iDTL_CommandReadWrite = 1'($urandom);
    check("cmd_accept_busy", oDTL_CommandAccept, 0);
  endtask

  task automatic doWrite(input logic [31:0] addr, input int bs, input logic [15:0] bePat,
                         input logic [GW-1:0] expFirst, input logic [GW-1:0] expLast,
                         input bit gaps, input int earlyIdx);
    int n = bs + 1;
    int last = (earlyIdx >= 0) ? earlyIdx : n - 1;
    logic [W-1:0] d;
    logic [3:0] be;
    logic [GW-1:0] w;
    issueCmd(1'b1, addr, bs);
    check("wr_accept_c1", oDTL_WriteAccept, 1);
    for (int i = 0; i <= last; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        iDTL_WriteValid = 1'b0;
        repeat ($urandom_range(1, 3)) nextCycle();
      end
      d = $urandom;
      be = bePat[4*(i%4) +: 4];
      iDTL_WriteValid = 1'b1; iDTL_WriteEnable = be; iDTL_WriteData = d;
      iDTL_WriteLast = (i == last);
      #1;
      check("wr_accept", oDTL_WriteAccept, 1);
      nextCycle();
      w = (i == n - 1) ? expLast : GW'((int'(expFirst) + i) % DEPTH);
      check("wr_sram_addr", oMEM_Address, w);
      check("wr_sram_be", oMEM_WriteEnable, be);
      check("wr_sram_data", oMEM_WriteData, d);
      for (int b = 0; b < 4; b++) if (be[b]) refMem[w][8*b +: 8] = d[8*b +: 8];
      expWrites++;
      check("wr_accept_after", oDTL_WriteAccept, (i != last));
    end
    iDTL_WriteValid = 1'b0; iDTL_WriteLast = 1'b0;
    check("wr_cmd_idle", oDTL_CommandAccept, 1);
  endtask

  // mode 0: accept always, 1: 1,0,0,1 pattern, 2: random
  task automatic doRead(input logic [31:0] addr, input int bs, input int mode,
                        input logic [GW-1:0] expFirst, input logic [GW-1:0] expLast);
    int n = bs + 1;
    int got = 0;
    int cyc = 1;
    bit held = 1'b0;
    bit acc;
    logic [W-1:0] hd;
    logic [GW-1:0] w;
    issueCmd(1'b0, addr, bs);
    check("rd_issue_c1", oMEM_ReadEnable, 1);
    check("rd_addr_c1", oMEM_Address, expFirst);
    check("rd_valid_c1", oDTL_ReadValid, 0);
    while (got < n && cyc < 400) begin
      case (mode)
        0: acc = 1'b1;
        1: acc = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: acc = 1'($urandom);
      endcase
      iDTL_ReadAccept = acc;
      #1;
      if (held) begin
        check("rd_hold_valid", oDTL_ReadValid, 1);
        check("rd_hold_data", oDTL_ReadData, hd);
      end
      held = 1'b0;
      if (oDTL_ReadValid) begin
        if (mode == 0) check("rd_no_bubble_cycle", cyc, got + 2);
        if (acc) begin
          w = (got == n - 1) ? expLast : GW'((int'(expFirst) + got) % DEPTH);
          check("rd_data", oDTL_ReadData, refMem[w]);
          check("rd_last", oDTL_ReadLast, (got == n - 1));
          got++;
        end else begin
          held = 1'b1;
          hd = oDTL_ReadData;
        end
      end
      nextCycle();
      cyc++;
    end
    iDTL_ReadAccept = 1'b0;
    check("rd_beats_complete", got, n);
    expReads += n;
    check("rd_cmd_idle", oDTL_CommandAccept, 1);
    check("rd_valid_idle", oDTL_ReadValid, 0);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_cmd_accept"}, oDTL_CommandAccept, 0);
    check({tag, "_wr_accept"}, oDTL_WriteAccept, 0);
    check({tag, "_rd_valid"}, oDTL_ReadValid, 0);
    check({tag, "_rd_data"}, oDTL_ReadData, 0);
    check({tag, "_rd_last"}, oDTL_ReadLast, 0);
    check({tag, "_mem_addr"}, oMEM_Address, 0);
    check({tag, "_mem_we"}, oMEM_WriteEnable, 0);
    check({tag, "_mem_wd"}, oMEM_WriteData, 0);
    check({tag, "_mem_re"}, oMEM_ReadEnable, 0);
  endtask

  typedef struct {
    bit            rw;
    logic [31:0]   addr;
    int            bs;
    logic [15:0]   bePat;
    int            mode;
    logic [GW-1:0] expFirst;
    logic [GW-1:0] expLast;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0040,  3, 16'hFC3F, 0, 10'h010, 10'h013};
    vecs[1] = '{1'b0, 32'h0000_0040,  3, 16'h0000, 0, 10'h010, 10'h013};
    vecs[2] = '{1'b1, 32'h0000_0100,  7, 16'h5A69, 0, 10'h040, 10'h047};
    vecs[3] = '{1'b0, 32'h0000_0100,  7, 16'h0000, 1, 10'h040, 10'h047};
    vecs[4] = '{1'b1, 32'h0000_0FFC,  1, 16'hFFFF, 0, 10'h3FF, 10'h000};
    vecs[5] = '{1'b0, 32'h0000_0FFC,  1, 16'h0000, 0, 10'h3FF, 10'h000};
    vecs[6] = '{1'b1, 32'hABCD_1003,  0, 16'h0008, 0, 10'h000, 10'h000};
    vecs[7] = '{1'b0, 32'hABCD_1003,  0, 16'h0000, 0, 10'h000, 10'h000};
    vecs[8] = '{1'b1, 32'h0000_03F8, 31, 16'hF1E3, 0, 10'h0FE, 10'h11D};
    vecs[9] = '{1'b0, 32'h0000_03F8, 31, 16'h0000, 2, 10'h0FE, 10'h11D};

    for (int i = 0; i < DEPTH; i++) refMem[i] = initVal(i);
    iReset = 1'b0; iDTL_CommandValid = 1'b0; iDTL_CommandReadWrite = 1'b0;
    iDTL_Address = '0; iDTL_BlockSize = '0; iDTL_WriteValid = 1'b0;
    iDTL_WriteEnable = '0; iDTL_WriteData = '0; iDTL_WriteLast = 1'b0;
    iDTL_ReadAccept = 1'b0;

    repeat (3) @(negedge iClk);
    #1;
    checkAllZero("por");
    iReset = 1'b1;
    #1;
    check("por_cmd_accept", oDTL_CommandAccept, 1);
    @(negedge iClk);

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].rw)
        doWrite(vecs[v].addr, vecs[v].bs, vecs[v].bePat, vecs[v].expFirst, vecs[v].expLast, 1'b0, -1);
      else
        doRead(vecs[v].addr, vecs[v].bs, vecs[v].mode, vecs[v].expFirst, vecs[v].expLast);
    end

    // Reset in the middle of a stalled read burst.
    issueCmd(1'b0, 32'h80, 7);
    iDTL_ReadAccept = 1'b0;
    repeat (3) nextCycle();
    expReads += 2;
    iReset = 1'b0;
    #1;
    checkAllZero("rst_mid");
    repeat (3) begin
      nextCycle();
      #1;
      check("rst_hold_re", oMEM_ReadEnable, 0);
      check("rst_hold_we", oMEM_WriteEnable, 0);
      check("rst_hold_valid", oDTL_ReadValid, 0);
    end
    iReset = 1'b1;
    #1;
    check("rst_rel_cmd_accept", oDTL_CommandAccept, 1);
    check("rst_rel_valid", oDTL_ReadValid, 0);
    check("rst_rel_wr_accept", oDTL_WriteAccept, 0);
    nextCycle();
    check("rst_after_re", oMEM_ReadEnable, 0);
    check("rst_after_valid", oDTL_ReadValid, 0);

`ifdef DTL_GM_PROTOCOL_CHECK_EN
    check("err_initial", oError, 0);
    doWrite(32'h200, 3, 16'hFFFF, 10'h080, 10'h083, 1'b0, 1);
    check("err_set", oError, 1);
    doRead(32'h200, 1, 0, 10'h080, 10'h081);
    check("err_sticky", oError, 1);
    iReset = 1'b0;
    #1;
    check("err_cleared", oError, 0);
    iReset = 1'b1;
    nextCycle();
`endif

    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      int bs;
      logic [15:0] pat;
      logic [GW-1:0] ef;
      logic [GW-1:0] el;
      a   = $urandom;
      bs  = ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 12);
      pat = {4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)),
             4'($urandom_range(1, 15)), 4'($urandom_range(1, 15))};
      ef  = GW'((a / 4) % DEPTH);
      el  = GW'((int'(ef) + bs) % DEPTH);
      if ($urandom_range(0, 1) == 1)
        doWrite(a, bs, pat, ef, el, 1'($urandom), -1);
      else
        doRead(a, bs, $urandom_range(0, 2), ef, el);
    end

    repeat (3) nextCycle();
    check("sram_write_count", monWrites, expWrites);
    check("sram_read_count", monIssued, expReads);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dtl_gm_slave.md
# dtl_gm_slave

Global-memory target for the CGRA core's DMEM DTL master port (non-native GM build). Accepts DTL read/write block commands, converts them into single-port synchronous SRAM accesses, and returns read data over DTL with full ReadAccept back-pressure. It sits directly downstream of the core's oDTL_DMEM_* outputs, between the core and the global data SRAM.

## Interface

Parameters:
- INTERFACE_WIDTH, 32, DTL data width (bits); byte enables = INTERFACE_WIDTH/8
- INTERFACE_ADDR_WIDTH, 32, DTL byte address width
- INTERFACE_BLOCK_WIDTH, 5, DTL block size field width (beats minus one)
- GM_MEM_ADDR_WIDTH, 10, SRAM word address width

Ports:
- iClk  in  1  clock
- iReset  in  1  asynchronous, active-low reset
- iDTL_CommandValid  in  1  command request
- oDTL_CommandAccept  out  1  command taken
- iDTL_CommandReadWrite  in  1  1 = write, 0 = read
- iDTL_Address  in  INTERFACE_ADDR_WIDTH  byte start address
- iDTL_BlockSize  in  INTERFACE_BLOCK_WIDTH  beats minus one
- iDTL_WriteValid  in  1  write beat valid
- oDTL_WriteAccept  out  1  write beat taken
- iDTL_WriteEnable  in  INTERFACE_WIDTH/8  byte enables
- iDTL_WriteData  in  INTERFACE_WIDTH  write beat data
- iDTL_WriteLast  in  1  final write beat marker
- oDTL_ReadValid  out  1  read beat valid
- iDTL_ReadAccept  in  1  read beat taken
- oDTL_ReadData  out  INTERFACE_WIDTH  read beat data
- oDTL_ReadLast  out  1  final read beat marker
- oMEM_Address  out  GM_MEM_ADDR_WIDTH  SRAM word address
- oMEM_WriteEnable  out  INTERFACE_WIDTH/8  SRAM byte write enables
- oMEM_WriteData  out  INTERFACE_WIDTH  SRAM write data
- oMEM_ReadEnable  out  1  SRAM read strobe
- iMEM_ReadData  in  INTERFACE_WIDTH  SRAM data, valid one cycle after oMEM_ReadEnable
- oError  out  1  sticky protocol error (only with DTL_GM_PROTOCOL_CHECK_EN)

## Operation

- States: IDLE, WRITE, READ.
- IDLE: oDTL_CommandAccept = 1. On CommandValid: latch word address = iDTL_Address[GM_MEM_ADDR_WIDTH+1:2], beat count = BlockSize+1, direction; go WRITE or READ. Address bits [1:0] ignored.
- WRITE: oDTL_WriteAccept = 1. Each accepted beat registered to SRAM: next cycle oMEM_WriteEnable = iDTL_WriteEnable, oMEM_WriteData, oMEM_Address = current address; address +1, count −1. Final beat (count reaches 0) -> IDLE.
- READ: 2-entry output FIFO. Issue oMEM_ReadEnable at current address when issues remain and (FIFO occupancy + in-flight) < 2; address +1 per issue. Returned data pushed into FIFO. oDTL_ReadValid = FIFO non-empty; ReadData = FIFO head; ReadLast = 1 when head is final beat. Pop on ReadValid & ReadAccept; push and pop in same cycle allowed. Pop of last beat -> IDLE.
- Address wraps modulo 2^GM_MEM_ADDR_WIDTH within a burst.
- oMEM_WriteEnable = 0 and oMEM_ReadEnable = 0 whenever no access is issued; SRAM never read and written in the same cycle.
- No new command accepted until the current burst fully completes (CommandAccept = 0 outside IDLE).

## Timing

- Reset (iReset = 0, async): state IDLE, FIFO empty, counters cleared; all outputs 0 except oDTL_CommandAccept = 1 after reset deassert. Reset mid-burst abandons the burst; no further SRAM access issued.
- Command accepted at edge 0 -> WRITE/READ from cycle 1.
- Write: beat accepted at edge k -> SRAM write at cycle k+1. Sustained one beat/cycle.
- Read: first oMEM_ReadEnable cycle 1, first ReadValid cycle 2. With ReadAccept held 1: one beat/cycle, no bubbles. With ReadAccept = 0: at most 2 beats buffered, issue stalls, no data lost or duplicated.
- ReadValid/ReadData stable while ReadAccept = 0.

## Configuration

- DTL_GM_PROTOCOL_CHECK_EN defined: oError port present; set (sticky until reset) when iDTL_WriteLast = 1 on a non-final beat, or = 0 on the final beat. An early WriteLast terminates the burst (-> IDLE) after writing that beat.
- Not defined: oError port absent; iDTL_WriteLast ignored; burst length taken solely from BlockSize.

## Test plan

- Reset: hold iReset = 0 mid-read burst -> all outputs 0, no SRAM strobes; release -> CommandAccept = 1, IDLE.
- Write 4 beats at 0x40, BlockSize = 3, enables 0xF,0x3,0xC,0xF -> SRAM writes words 0x10..0x13 with those enables, one per cycle, WriteAccept high 4 cycles.
- Read 4 beats at 0x40, ReadAccept = 1 -> ReadValid cycles 2..5, data words 0x10..0x13, ReadLast only on cycle 5.
- Read 8 beats with ReadAccept toggled 1,0,0,1,… -> all 8 words in order, none duplicated, SRAM reads never exceed 2 outstanding.
- Write 2 beats at 0xFFC with GM_MEM_ADDR_WIDTH = 10 -> writes words 0x3FF then 0x000.
- With DTL_GM_PROTOCOL_CHECK_EN: 4-beat write, WriteLast on beat 2 -> 2 SRAM writes, oError = 1, back to IDLE, oError held until reset.
